// File: rtl/nco_pkg.sv
// Shared constants, quadrant type, phase folding and the quarter-wave sine table.
package nco_pkg;
  localparam int DEG_FULL    = 360;
  localparam int DEG_QUARTER = 90;
  localparam int QTAB_DEPTH  = 91;
  localparam int QTAB_W      = 16;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

  typedef struct packed {
    logic [6:0] idx;
    logic       neg;
  } fold_t;

  // Entry k = round(32767 * sin(k deg)); indices above 90 are never addressed.
  function automatic logic [QTAB_W-1:0] qtab_entry(input logic [6:0] k);
    logic [QTAB_W-1:0] e;
    e = '0;
    case (k)
      7'd0:  e = 16'd0;     7'd1:  e = 16'd572;   7'd2:  e = 16'd1144;  7'd3:  e = 16'd1715;
      7'd4:  e = 16'd2286;  7'd5:  e = 16'd2856;  7'd6:  e = 16'd3425;  7'd7:  e = 16'd3993;
      7'd8:  e = 16'd4560;  7'd9:  e = 16'd5126;  7'd10: e = 16'd5690;  7'd11: e = 16'd6252;
      7'd12: e = 16'd6813;  7'd13: e = 16'd7371;  7'd14: e = 16'd7927;  7'd15: e = 16'd8481;
      7'd16: e = 16'd9032;  7'd17: e = 16'd9580;  7'd18: e = 16'd10126; 7'd19: e = 16'd10668;
      7'd20: e = 16'd11207; 7'd21: e = 16'd11743; 7'd22: e = 16'd12275; 7'd23: e = 16'd12803;
      7'd24: e = 16'd13328; 7'd25: e = 16'd13848; 7'd26: e = 16'd14364; 7'd27: e = 16'd14876;
      7'd28: e = 16'd15383; 7'd29: e = 16'd15886; 7'd30: e = 16'd16384; 7'd31: e = 16'd16876;
      7'd32: e = 16'd17364; 7'd33: e = 16'd17846; 7'd34: e = 16'd18323; 7'd35: e = 16'd18794;
      7'd36: e = 16'd19260; 7'd37: e = 16'd19720; 7'd38: e = 16'd20173; 7'd39: e = 16'd20621;
      7'd40: e = 16'd21062; 7'd41: e = 16'd21497; 7'd42: e = 16'd21925; 7'd43: e = 16'd22347;
      7'd44: e = 16'd22762; 7'd45: e = 16'd23170; 7'd46: e = 16'd23571; 7'd47: e = 16'd23964;
      7'd48: e = 16'd24351; 7'd49: e = 16'd24730; 7'd50: e = 16'd25101; 7'd51: e = 16'd25465;
      7'd52: e = 16'd25821; 7'd53: e = 16'd26169; 7'd54: e = 16'd26509; 7'd55: e = 16'd26841;
      7'd56: e = 16'd27165; 7'd57: e = 16'd27481; 7'd58: e = 16'd27788; 7'd59: e = 16'd28087;
      7'd60: e = 16'd28377; 7'd61: e = 16'd28659; 7'd62: e = 16'd28932; 7'd63: e = 16'd29196;
      7'd64: e = 16'd29451; 7'd65: e = 16'd29697; 7'd66: e = 16'd29934; 7'd67: e = 16'd30162;
      7'd68: e = 16'd30381; 7'd69: e = 16'd30591; 7'd70: e = 16'd30791; 7'd71: e = 16'd30982;
      7'd72: e = 16'd31163; 7'd73: e = 16'd31335; 7'd74: e = 16'd31498; 7'd75: e = 16'd31650;
      7'd76: e = 16'd31794; 7'd77: e = 16'd31927; 7'd78: e = 16'd32051; 7'd79: e = 16'd32165;
      7'd80: e = 16'd32269; 7'd81: e = 16'd32364; 7'd82: e = 16'd32448; 7'd83: e = 16'd32523;
      7'd84: e = 16'd32587; 7'd85: e = 16'd32642; 7'd86: e = 16'd32687; 7'd87: e = 16'd32722;
      7'd88: e = 16'd32747; 7'd89: e = 16'd32762; 7'd90: e = 16'd32767;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [8:0] deg_reduce(input logic [8:0] p);
    return (p >= 9'(DEG_FULL)) ? p - 9'(DEG_FULL) : p;
  endfunction

  function automatic logic [8:0] cos_deg(input logic [8:0] p);
    logic [8:0] s;
    s = deg_reduce(p) + 9'(DEG_QUARTER);
    return (s >= 9'(DEG_FULL)) ? s - 9'(DEG_FULL) : s;
  endfunction

  function automatic fold_t deg_fold(input logic [8:0] p);
    logic [8:0] d;
    logic [8:0] t;
    quad_e      q;
    fold_t      f;
    d = deg_reduce(p);
    if (d < 9'(DEG_QUARTER))          q = Q0;
    else if (d < 9'(2*DEG_QUARTER))   q = Q1;
    else if (d < 9'(3*DEG_QUARTER))   q = Q2;
    else                              q = Q3;
    case (q)
      Q0:      t = d;
      Q1:      t = 9'(2*DEG_QUARTER) - d;
      Q2:      t = d - 9'(2*DEG_QUARTER);
      Q3:      t = 9'(DEG_FULL) - d;
      default: t = d;
    endcase
    f.idx = t[6:0];
    f.neg = (q == Q2) || (q == Q3);
    return f;
  endfunction
endpackage

// File: rtl/nco_quarter_rom.sv
// Quarter-wave sine table with two registered read ports; both ports load only when en is high.
module nco_quarter_rom
  import nco_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [6:0]        idx_a,
  input  logic [6:0]        idx_b,
  output logic [QTAB_W-1:0] mag_a,
  output logic [QTAB_W-1:0] mag_b
);
  logic [QTAB_W-1:0] mag_a_d, mag_a_q;
  logic [QTAB_W-1:0] mag_b_d, mag_b_q;

  always_comb begin
    mag_a_d = qtab_entry(idx_a);
    mag_b_d = qtab_entry(idx_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a_q <= '0;
      mag_b_q <= '0;
    end else if (en) begin
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
    end
  end

  assign mag_a = mag_a_q;
  assign mag_b = mag_b_q;
endmodule

// File: rtl/nco_sine_lut.sv
// Degree phase -> signed sine via folded quarter ROM; 3-cycle latency, whole pipe stalls when output is held.
// Defining NCO_COS_OUT_EN adds cos_out computed through the ROM's second read port.
module nco_sine_lut
  import nco_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PHASE_W-1:0]       phase_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] sin_out,
`ifdef NCO_COS_OUT_EN
  output logic signed [DATA_W-1:0] cos_out,
`endif
  output logic                     out_valid,
  input  logic                     out_ready
);
  generate
    if (PHASE_W != 9) begin : g_bad_phase_w
      $error("nco_sine_lut: PHASE_W must be 9");
    end
  endgenerate

  localparam int SHIFT = QTAB_W - DATA_W;

  function automatic logic signed [DATA_W-1:0] scale(input logic [QTAB_W-1:0] mag,
                                                     input logic neg);
    logic signed [QTAB_W-1:0] sh;
    logic signed [DATA_W-1:0] m;
    sh = $signed(mag) >>> SHIFT;
    m  = sh[DATA_W-1:0];
    return neg ? -m : m;
  endfunction

  logic                     adv;
  fold_t                    s1_sin_d, s1_sin_q;
  logic                     s1_vld_q;
  logic                     s2_vld_q, s2_neg_q;
  logic                     out_vld_q;
  logic signed [DATA_W-1:0] sin_d, sin_q;
  logic [QTAB_W-1:0]        mag_sin;

  assign adv      = !out_vld_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    s1_sin_d = deg_fold(phase_in);
    sin_d    = scale(mag_sin, s2_neg_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_sin_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_neg_q  <= 1'b0;
      out_vld_q <= 1'b0;
      sin_q     <= '0;
    end else if (adv) begin
      s1_vld_q  <= in_valid;
      s1_sin_q  <= s1_sin_d;
      s2_vld_q  <= s1_vld_q;
      s2_neg_q  <= s1_sin_q.neg;
      out_vld_q <= s2_vld_q;
      sin_q     <= sin_d;
    end
  end

  assign sin_out   = sin_q;
  assign out_valid = out_vld_q;

`ifdef NCO_COS_OUT_EN
  // cos(d) = sin(d + 90), folded alongside the sine path.
  fold_t                    s1_cos_d, s1_cos_q;
  logic                     s2_cneg_q;
  logic signed [DATA_W-1:0] cos_d, cos_q;
  logic [QTAB_W-1:0]        mag_cos;

  always_comb begin
    s1_cos_d = deg_fold(cos_deg(phase_in));
    cos_d    = scale(mag_cos, s2_cneg_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_cos_q  <= '0;
      s2_cneg_q <= 1'b0;
      cos_q     <= '0;
    end else if (adv) begin
      s1_cos_q  <= s1_cos_d;
      s2_cneg_q <= s1_cos_q.neg;
      cos_q     <= cos_d;
    end
  end

  assign cos_out = cos_q;

  nco_quarter_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .idx_a (s1_sin_q.idx),
    .idx_b (s1_cos_q.idx),
    .mag_a (mag_sin),
    .mag_b (mag_cos)
  );
`else
  logic [QTAB_W-1:0] unused_mag_b;

  nco_quarter_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .idx_a (s1_sin_q.idx),
    .idx_b (7'd0),
    .mag_a (mag_sin),
    .mag_b (unused_mag_b)
  );
`endif
endmodule

// File: tb/tb_nco_sine_lut.sv
// Scoreboard bench for nco_sine_lut: directed phases with hand-computed sine/cosine samples.
module tb_nco_sine_lut;
  logic               clk;
  logic               rst_n;
  logic [8:0]         phase_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] sin_out;
`ifdef NCO_COS_OUT_EN
  logic signed [15:0] cos_out;
`endif
  logic               out_valid;
  logic               out_ready;

  nco_sine_lut #(.DATA_W(16), .PHASE_W(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase_in  (phase_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sin_out   (sin_out),
`ifdef NCO_COS_OUT_EN
    .cos_out   (cos_out),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    int s;
    int c;
    int cyc;
    bit lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one phase and push its expectation when the handshake is seen.
  task automatic send(input int ph, input int s, input int c, input bit lat);
    exp_t e;
    int   n;
    phase_in = 9'(ph);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    else begin
      e.s = s; e.c = c; e.cyc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sin_out", int'(sin_out), e.s);
`ifdef NCO_COS_OUT_EN
        chk("cos_out", int'(cos_out), e.c);
`endif
        if (e.lat) chk("latency", cyc - e.cyc, 3);
      end
    end
  end

  int t1_ph[5] = '{0, 30, 90, 210, 270};
  int t1_s[5]  = '{0, 16384, 32767, -16384, -32767};
  int t1_c[5]  = '{32767, 28377, 0, -28377, 0};
  int t2_ph[8] = '{390, 360, 135, 300, 511, 179, 359, 180};
  int t2_s[8]  = '{16384, 0, 23170, -28377, 15886, 572, -572, 0};
  int t2_c[8]  = '{28377, 32767, -23170, 16384, -28659, -32762, 32762, -32767};
  int t3_s[10] = '{0, 572, 1144, 1715, 2286, 2856, 3425, 3993, 4560, 5126};
  int t3_c[10] = '{32767, 32762, 32747, 32722, 32687, 32642, 32587, 32523, 32448, 32364};

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; phase_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_sin_out", int'(sin_out), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) send(t1_ph[i], t1_s[i], t1_c[i], 1'b1);
    in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;

    for (int i = 0; i < 8; i++) send(t2_ph[i], t2_s[i], t2_c[i], 1'b1);
    in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;

    fork
      begin
        for (int k = 0; k < 10; k++) send(k, t3_s[k], t3_c[k], 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", int'(in_ready), 0);
          chk("stall_out_valid", int'(out_valid), 1);
          chk("stall_hold", int'(sin_out), (sb.size() != 0) ? sb[0].s : 99999);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;

    send(30, 16384, 28377, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    send(90, 32767, 0, 1'b1);
    in_valid = 1'b0;
    repeat (6) @(posedge clk); #1;

    send(90, 32767, 0, 1'b0);
    send(210, -16384, -28377, 1'b0);
    send(270, -32767, 0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_sin_out", int'(sin_out), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_no_stale", int'(out_valid), 0);
    end
    @(posedge clk); #1;

    n = 0;
    while (sb.size() != 0 && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("drain_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nco_sine_lut.md
Name: nco_sine_lut

Overview:
- Downstream stage of the modulo-360 reducer in the LUT-based NCO.
- Consumes a registered phase in degrees (0..359) and returns a signed sine sample from a quarter-wave ROM (91 entries, 0..90 deg), using quadrant folding and sign restoration.
- Three-stage pipeline with a valid/ready handshake so the DAC/mixer side can stall it.

Parameters:
- DATA_W, 16, output sample width (8..16). The table is stored at 16 bits and arithmetically right-shifted by (16-DATA_W) at output.
- PHASE_W, 9, phase input width. Fixed at 9; any other value is a elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- phase_in  input  PHASE_W  phase in degrees, nominally 0..359
- in_valid  input  1  phase_in valid
- in_ready  output  1  stage accepts phase_in this cycle
- sin_out  output  DATA_W  signed sine sample, full scale = 2^(DATA_W-1)-1
- out_valid  output  1  sin_out valid
- out_ready  input  1  consumer accepts sin_out this cycle

Behaviour:
- Reset (async assert, sync deassert by upstream):
  - All stage valid bits = 0.
  - sin_out = 0, out_valid = 0.
  - Reset mid-operation discards all in-flight samples; nothing is replayed.
- Global advance:
  - adv = !out_valid || out_ready.
  - All stages load only when adv = 1.
  - in_ready = adv (combinational).
  - Input transfer = in_valid && in_ready.
- Latency: 3 clk edges from input transfer to out_valid with no stall. Throughput is 1 sample/clk.
- Stalls:
  - While stalled, sin_out and out_valid hold their values.
  - No sample is dropped or duplicated.
- Bubbles: empty stages propagate valid = 0. Bubbles are not compressed while stalled.
- Stage 1, range fold and quadrant:
  - If phase_in >= 360, subtract 360 (e.g. 390 -> 30, 511 -> 151).
  - Then map degree d to index and negate flag:
    - q0 (0..89): idx = d, neg = 0
    - q1 (90..179): idx = 180-d, neg = 0
    - q2 (180..269): idx = d-180, neg = 1
    - q3 (270..359): idx = 360-d, neg = 1
  - Register idx (7 bits), neg, and valid.
- Stage 2, ROM read:
  - Registered read of the quarter table. Entry k = round(32767*sin(k deg)), k = 0..90.
  - Entry 0 = 0; entry 90 = 32767.
  - Register magnitude (16 bits unsigned-in-signed), neg, and valid.
- Stage 3, output:
  - sin_out = neg ? -(mag >>> shift) : (mag >>> shift).
  - Negative full scale is -(2^(DATA_W-1)-1); the most negative code is never produced.
  - Zero magnitude with neg = 1 yields 0, not -0 or overflow.

Optional Feature:
- Macro: NCO_COS_OUT_EN.
- Defined:
  - Adds port cos_out (output, DATA_W, signed), sharing out_valid/out_ready.
  - Cos is computed as the sine of (d+90) mod 360, folded in stage 1 in parallel, using a second ROM read port on the same table.
  - Same latency and stall behaviour; cos_out resets to 0.
- Undefined: the port and the second read path are absent. sin_out behaviour is identical in both builds.

Decomposition:
- Shared package nco_pkg holds:
  - DEG_FULL = 360, DEG_QUARTER = 90, QTAB_DEPTH = 91, QTAB_W = 16.
  - Quadrant enum typedef (Q0..Q3).
  - The quarter-table constant function returning entry k.
- One sub-module: nco_quarter_rom. It is a registered dual-read ROM (idx_a/idx_b in, mag_a/mag_b out, enable = adv). The top instantiates one; port b is unused when NCO_COS_OUT_EN is undefined.

Test Plan:
- Reset, then phase_in = 0, 30, 90, 210, 270 back-to-back with out_ready = 1 -> after 3 clk, sin_out = 0, 16384, 32767, -16384, -32767 on consecutive cycles.
- Out-of-range phase_in = 390 and 360 -> sin_out = 16384 and 0.
- Backpressure: stream 0..9 deg with out_ready low for 4 cycles mid-stream -> in_ready low during the stall, sin_out held, output sequence complete and in order with no duplicates.
- Bubbles: in_valid toggling 1,0,1 -> out_valid pattern 1,0,1 delayed by 3 cycles.
- Reset asserted with 3 samples in flight -> out_valid drops immediately, sin_out = 0, and no stale sample appears after release.
- NCO_COS_OUT_EN build: phase_in = 30 -> cos_out = 28377. phase_in = 180 -> cos_out = -32767 and sin_out = 0.
